// File: rtl/pip_resolve.sv
// pip_resolve: execute-stage next-PC resolution for JAL/JALR/BRANCH and
// sequential instructions. A wrong fetch prediction raises a held redirect
// to fetch, then flushes the wrong-path IF/ID stages for FLUSH_CYCLES cycles.
// Optional macro YSYX22040228_RESOLVE_PERF_EN adds the perf_ctrl_cnt and
// perf_miss_cnt event counters.
module pip_resolve #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [63:0] RESET_PC     = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [63:0] ex_pc,
   input  logic [31:0] ex_inst,
   input  logic [63:0] ex_pred_pc,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        mispredict
`ifdef YSYX22040228_RESOLVE_PERF_EN
   ,
   output logic [31:0] perf_ctrl_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDIRECT,
      ST_FLUSH
   } state_e;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_e      state_q, state_d;
   logic [63:0] redirect_pc_q, redirect_pc_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_jal, is_jalr, is_branch, is_ctrl;
   logic [63:0] j_imm, b_imm, i_imm;
   logic        br_taken;
   logic [63:0] actual_pc;
   logic        detect;

   assign opcode    = ex_inst[6:0];
   assign funct3    = ex_inst[14:12];
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_branch = (opcode == 7'b1100011);
   assign is_ctrl   = is_jal | is_jalr | is_branch;

   assign j_imm = {{44{ex_inst[31]}}, ex_inst[19:12], ex_inst[20], ex_inst[30:21], 1'b0};
   assign b_imm = {{52{ex_inst[31]}}, ex_inst[7], ex_inst[30:25], ex_inst[11:8], 1'b0};
   assign i_imm = {{52{ex_inst[31]}}, ex_inst[31:20]};

   // Branch condition evaluation; reserved funct3 encodings fall through as not-taken.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      br_taken = 1'b0;
      unique case (funct3)
         3'b000:  br_taken = (rs1_data == rs2_data);
         3'b001:  br_taken = (rs1_data != rs2_data);
         3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  br_taken = (rs1_data <  rs2_data);
         3'b111:  br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   // True successor PC of the EX instruction.
   always_comb begin
      actual_pc = ex_pc + 64'd4;
      if (is_jal) begin
         actual_pc = ex_pc + j_imm;
      end else if (is_jalr) begin
         actual_pc = (rs1_data + i_imm) & ~64'd1;
      end else if (is_branch && br_taken) begin
         actual_pc = ex_pc + b_imm;
      end
   end

   // Detection is only meaningful in IDLE; elsewhere EX holds wrong-path work.
   assign detect = (state_q == ST_IDLE) && ex_valid && (actual_pc != ex_pred_pc);

   // Next-state and output decode for the redirect/flush sequencer.
   always_comb begin
      state_d        = state_q;
      redirect_pc_d  = redirect_pc_q;
      flush_cnt_d    = flush_cnt_q;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      mispredict     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            mispredict = detect;
            if (detect) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = actual_pc;
            end
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            if (redirect_ready) begin
               if (FLUSH_CYCLES == 0) begin
                  state_d     = ST_IDLE;
                  flush_cnt_d = 4'd0;
               end else begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (flush_cnt_q <= 4'd1) begin
               state_d     = ST_IDLE;
               flush_cnt_d = 4'd0;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            flush_cnt_d = 4'd0;
         end
      endcase
   end

   // State, latched redirect target and flush counter, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= RESET_PC;
         flush_cnt_q   <= 4'd0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign redirect_pc = redirect_pc_q;

`ifdef YSYX22040228_RESOLVE_PERF_EN
   logic [31:0] perf_ctrl_cnt_q, perf_miss_cnt_q;

   // Event counters: control instructions resolved in IDLE and mispredict pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ctrl_cnt_q <= 32'd0;
         perf_miss_cnt_q <= 32'd0;
      end else begin
         if ((state_q == ST_IDLE) && ex_valid && is_ctrl) begin
            perf_ctrl_cnt_q <= perf_ctrl_cnt_q + 32'd1;
         end
         if (mispredict) begin
            perf_miss_cnt_q <= perf_miss_cnt_q + 32'd1;
         end
      end
   end

   assign perf_ctrl_cnt = perf_ctrl_cnt_q;
   assign perf_miss_cnt = perf_miss_cnt_q;
`endif

endmodule

// File: tb/tb_pip_resolve.sv
// tb_pip_resolve: directed scenarios plus randomized traffic for pip_resolve,
// checked every cycle against a behavioural next-PC / redirect model.
module tb_pip_resolve;

   localparam int          FC  = 2;
   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   localparam logic [31:0] BEQ_I  = 32'h00208863;
   localparam logic [31:0] BNE_I  = 32'h00209863;
   localparam logic [31:0] JALR_I = 32'h004080E7;
   localparam logic [31:0] ADDI_I = 32'h00000013;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [63:0] ex_pc;
   logic [31:0] ex_inst;
   logic [63:0] ex_pred_pc;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        redirect_ready;
   logic        flush;
   logic        mispredict;
`ifdef YSYX22040228_RESOLVE_PERF_EN
   logic [31:0] perf_ctrl_cnt;
   logic [31:0] perf_miss_cnt;
`endif

   pip_resolve #(.FLUSH_CYCLES(FC), .RESET_PC(RPC)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_inst        (ex_inst),
      .ex_pred_pc     (ex_pred_pc),
      .rs1_data       (rs1_data),
      .rs2_data       (rs2_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .flush          (flush),
      .mispredict     (mispredict)
`ifdef YSYX22040228_RESOLVE_PERF_EN
      ,
      .perf_ctrl_cnt  (perf_ctrl_cnt),
      .perf_miss_cnt  (perf_miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference next PC, computed straight from the ISA rules with integer math.
   function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [31:0] inst,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] jimm, bimm, iimm;
      longint      sa, sb;
      bit          take;
      jimm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      bimm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      iimm = {{52{inst[31]}}, inst[31:20]};
      sa = longint'(a);
      sb = longint'(b);
      case (inst[6:0])
         7'h6F: return pc + jimm;
         7'h67: return {(a + iimm) >> 1, 1'b0};
         7'h63: begin
            case (inst[14:12])
               3'd0:    take = (a == b);
               3'd1:    take = (a != b);
               3'd4:    take = (sa < sb);
               3'd5:    take = !(sa < sb);
               3'd6:    take = (a < b);
               3'd7:    take = !(a < b);
               default: take = 1'b0;
            endcase
            return take ? pc + bimm : pc + 64'd4;
         end
         default: return pc + 64'd4;
      endcase
   endfunction

   function automatic bit is_ctrl_op(input logic [31:0] inst);
      return (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67) || (inst[6:0] == 7'h63);
   endfunction

   // Model: a pending redirect, a count of flush cycles still owed, last target.
   bit          m_pend    = 1'b0;
   int          m_left    = 0;
   logic [63:0] m_pc      = RPC;
   logic [31:0] m_ctrl    = 32'd0;
   logic [31:0] m_miss    = 32'd0;
   bit          m_started = 1'b0;

   function automatic bit m_idle();
      return !m_pend && (m_left == 0);
   endfunction

   function automatic bit m_mis();
      return m_idle() && ex_valid && (ref_next(ex_pc, ex_inst, rs1_data, rs2_data) != ex_pred_pc);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pend = 1'b0;
         m_left = 0;
         m_pc   = RPC;
         m_ctrl = 32'd0;
         m_miss = 32'd0;
      end else if (m_idle()) begin
         if (ex_valid && is_ctrl_op(ex_inst)) m_ctrl = m_ctrl + 32'd1;
         if (m_mis()) begin
            m_miss = m_miss + 32'd1;
            m_pend = 1'b1;
            m_pc   = ref_next(ex_pc, ex_inst, rs1_data, rs2_data);
         end
      end else if (m_pend) begin
         if (redirect_ready) begin
            m_pend = 1'b0;
            m_left = FC;
         end
      end else begin
         m_left = m_left - 1;
      end
      m_started = 1'b1;
   end

   // Every-cycle compare, mid-cycle when inputs and outputs have settled.
   always @(negedge clk) begin
      if (m_started) begin
         check("mispredict", 64'(mispredict), 64'(m_mis()));
         check("redirect_valid", 64'(redirect_valid), 64'(m_pend));
         check("flush", 64'(flush), 64'(m_pend || (m_left > 0)));
         check("redirect_pc", redirect_pc, m_pc);
`ifdef YSYX22040228_RESOLVE_PERF_EN
         check("perf_ctrl_cnt", 64'(perf_ctrl_cnt), 64'(m_ctrl));
         check("perf_miss_cnt", 64'(perf_miss_cnt), 64'(m_miss));
`endif
      end
   end

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                        input logic [63:0] pred, input logic [63:0] a, input logic [63:0] b,
                        input logic rdy);
      ex_valid       = v;
      ex_pc          = pc;
      ex_inst        = inst;
      ex_pred_pc     = pred;
      rs1_data       = a;
      rs2_data       = b;
      redirect_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in(input logic rdy);
      drive(1'b0, 64'd0, 32'd0, 64'd0, 64'd0, 64'd0, rdy);
   endtask

   logic [31:0] r_inst;
   logic [63:0] r_pc, r_a, r_b, r_pred;

   initial begin
      rst = 1'b1;
      idle_in(1'b0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset_rv", 64'(redirect_valid), 64'd0);
      check("reset_flush", 64'(flush), 64'd0);
      check("reset_rpc", redirect_pc, RPC);
      check("reset_mis", 64'(mispredict), 64'd0);
      step();

      // Correct BEQ prediction: nothing happens.
      drive(1'b1, 64'h80000010, BEQ_I, 64'h80000020, 64'd5, 64'd5, 1'b1);
      #1 check("beq_ok_mis", 64'(mispredict), 64'd0);
      step();
      idle_in(1'b1);
      #1;
      check("beq_ok_rv", 64'(redirect_valid), 64'd0);
      check("beq_ok_flush", 64'(flush), 64'd0);
      step();

      // BNE mispredict with immediate acceptance.
      drive(1'b1, 64'h80000010, BNE_I, 64'h80000020, 64'd5, 64'd5, 1'b1);
      #1 check("bne_mis", 64'(mispredict), 64'd1);
      step();
      idle_in(1'b1);
      #1;
      check("bne_rv_t1", 64'(redirect_valid), 64'd1);
      check("bne_rpc", redirect_pc, 64'h80000014);
      check("bne_flush_t1", 64'(flush), 64'd1);
      step();
      #1;
      check("bne_rv_t2", 64'(redirect_valid), 64'd0);
      check("bne_flush_t2", 64'(flush), 64'd1);
      step();
      #1 check("bne_flush_t3", 64'(flush), 64'd1);
      step();
      #1 check("bne_flush_t4", 64'(flush), 64'd0);

      // JALR target has bit 0 cleared.
      drive(1'b1, 64'h80001000, JALR_I, 64'h80001007, 64'h80001003, 64'd0, 1'b1);
      #1 check("jalr_mis", 64'(mispredict), 64'd1);
      step();
      idle_in(1'b1);
      #1 check("jalr_rpc", redirect_pc, 64'h80001006);
      step();
      step();
      step();

      // Back-pressure: redirect held while mismatching EX traffic is ignored.
      drive(1'b1, 64'h80000010, BNE_I, 64'h80000020, 64'd5, 64'd5, 1'b0);
      #1 check("bp_mis", 64'(mispredict), 64'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h80000010, BNE_I, 64'h80000020, 64'd5, 64'd5, (i == 3));
         #1;
         check("bp_rv_held", 64'(redirect_valid), 64'd1);
         check("bp_rpc_held", redirect_pc, 64'h80000014);
         check("bp_no_mis", 64'(mispredict), 64'd0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         check("bp_flush", 64'(flush), 64'd1);
         check("bp_flush_no_mis", 64'(mispredict), 64'd0);
         step();
      end
      idle_in(1'b1);
      #1 check("bp_done", 64'(flush), 64'd0);

      // Reset in the middle of the flush window.
      drive(1'b1, 64'h80000010, BNE_I, 64'h80000020, 64'd5, 64'd5, 1'b1);
      step();
      idle_in(1'b1);
      step();
      rst = 1'b1;
      #1 check("rstmid_flush_before", 64'(flush), 64'd1);
      step();
      rst = 1'b0;
      #1;
      check("rstmid_flush", 64'(flush), 64'd0);
      check("rstmid_rv", 64'(redirect_valid), 64'd0);
      check("rstmid_rpc", redirect_pc, RPC);
      drive(1'b1, 64'h80001000, JALR_I, 64'h80001007, 64'h80001003, 64'd0, 1'b1);
      #1 check("rstmid_fresh_mis", 64'(mispredict), 64'd1);
      step();
      idle_in(1'b1);
      #1;
      check("rstmid_fresh_rv", 64'(redirect_valid), 64'd1);
      check("rstmid_fresh_rpc", redirect_pc, 64'h80001006);
      step();
      step();
      step();

      // Non-control instruction with a wrong prediction.
      drive(1'b1, 64'h80000100, ADDI_I, 64'h80000200, 64'd0, 64'd0, 1'b1);
      #1 check("addi_mis", 64'(mispredict), 64'd1);
      step();
      idle_in(1'b1);
      #1 check("addi_rpc", redirect_pc, 64'h80000104);
      step();
      step();
      step();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         r_inst = $urandom;
         case ($urandom_range(0, 4))
            0:       r_inst[6:0] = 7'h6F;
            1:       r_inst[6:0] = 7'h67;
            2, 3:    r_inst[6:0] = 7'h63;
            default: ;
         endcase
         r_pc = {32'd0, $urandom} & ~64'd3;
         r_a  = {$urandom, $urandom};
         case ($urandom_range(0, 2))
            0:       r_b = r_a;
            1:       r_b = r_a ^ 64'h8000_0000_0000_0000;
            default: r_b = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0, 1:    r_pred = ref_next(r_pc, r_inst, r_a, r_b);
            2:       r_pred = r_pc + 64'd4;
            default: r_pred = {$urandom, $urandom};
         endcase
         drive(($urandom_range(0, 4) != 0), r_pc, r_inst, r_pred, r_a, r_b,
               $urandom_range(0, 1) == 1);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      idle_in(1'b1);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
